// File: rtl/zbt_pkg.sv
// zbt_pkg
// Shared definitions for the ZBT SRAM writers: the write-sequencer state
// encoding, the ZBT write-data latency and the default bus widths.
package zbt_pkg;

    // Cycles between a ZBT address/WE beat and its data on the pins.
    localparam int ZBT_WRITE_LATENCY = 2;

    localparam int ZBT_ADDR_WIDTH = 19;
    localparam int ZBT_DATA_WIDTH = 36;

    typedef enum logic [1:0] {
        ZBT_ST_IDLE  = 2'd0,
        ZBT_ST_WRITE = 2'd1,
        ZBT_ST_DRAIN = 2'd2,
        ZBT_ST_DONE  = 2'd3
    } zbt_state_e;

endpackage

// File: rtl/zbt_write_delay.sv
// zbt_write_delay
// DEPTH-deep valid+data shift register used by every ZBT writer to line
// write data up with the SRAM's pipelined write latency. A stage only loads
// new data when the beat entering it is valid, so the last stage (and hence
// the pins) holds its previous word while no beat is present.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low clear of all stages
//   in_valid  in   beat present at the input this cycle
//   in_data   in   W-bit beat data
//   out_valid out  beat present at the output (DEPTH cycles later)
//   out_data  out  W-bit output data, holds when out_valid is low
module zbt_write_delay
    import zbt_pkg::*;
#(
    parameter int W     = ZBT_DATA_WIDTH,
    parameter int DEPTH = ZBT_WRITE_LATENCY
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0]        vld;
    logic [DEPTH-1:0][W-1:0] dat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            dat <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/zbt_write_sequencer.sv
// zbt_write_sequencer
// Writes NUM_ENTRIES words from a combinational lookup table into the ZBT
// SRAM, one pipelined write per entry, once per start pulse. Address and WE
// are registered; the data word and its bus-drive enable follow two cycles
// later through a zbt_write_delay pipeline.
//
// Handshake: mem_grant is sampled on each rising edge while in WRITE; a
// granted edge issues exactly one beat for the current entry and advances
// to the next entry, an ungranted edge issues nothing and holds the entry.
// start is only looked at in IDLE.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset, abandons any run
//   start        in   begin a run (IDLE only)
//   mem_grant    in   arbiter grants the ZBT port this cycle
//   index        out  entry index to the lookup table
//   value        in   lookup result for index, same cycle
//   mem_addr     out  registered ZBT address
//   mem_we       out  registered ZBT write enable
//   mem_data     out  ZBT write data, two cycles after its address
//   mem_data_oe  out  tristate enable for mem_data, aligned with it
//   busy         out  run in progress
//   done         out  one-cycle pulse at end of run
module zbt_write_sequencer
    import zbt_pkg::*;
#(
    parameter int                    NUM_ENTRIES = 4,
    parameter int                    INDEX_WIDTH = 2,
    parameter int                    ADDR_WIDTH  = ZBT_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = ZBT_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   mem_grant,
    output logic [INDEX_WIDTH-1:0] index,
    input  logic [DATA_WIDTH-1:0]  value,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_we,
    output logic [DATA_WIDTH-1:0]  mem_data,
    output logic                   mem_data_oe,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] IDLE  = 2'(ZBT_ST_IDLE);
    localparam logic [1:0] WRITE = 2'(ZBT_ST_WRITE);
    localparam logic [1:0] DRAIN = 2'(ZBT_ST_DRAIN);
    localparam logic [1:0] DONE  = 2'(ZBT_ST_DONE);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_ENTRIES - 1);

    logic [1:0]             state;
    logic [INDEX_WIDTH-1:0] count;
    // DRAIN lasts exactly ZBT_WRITE_LATENCY (2) cycles; one bit marks the second.
    logic                   drain_second;
    logic                   s1_valid;
    logic [DATA_WIDTH-1:0]  s1_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            count        <= '0;
            drain_second <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            s1_valid     <= 1'b0;
            s1_data      <= '0;
        end else begin
            // Beats are only issued from WRITE on a granted edge.
            mem_we   <= 1'b0;
            s1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WRITE;
                        count <= '0;
                    end
                end
                WRITE: begin
                    if (mem_grant) begin
                        mem_addr <= BASE_ADDR + ADDR_WIDTH'(count);
                        mem_we   <= 1'b1;
                        s1_valid <= 1'b1;
                        s1_data  <= value;
                        count    <= count + 1'b1;
                        if (count == LAST_IDX) begin
                            state        <= DRAIN;
                            drain_second <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_second) begin
                        state <= DONE;
                    end else begin
                        drain_second <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // s1 is captured with the address; the delay line adds the remaining
    // ZBT_WRITE_LATENCY stages so data reaches the pins two cycles after WE.
    zbt_write_delay #(
        .W     (DATA_WIDTH),
        .DEPTH (ZBT_WRITE_LATENCY)
    ) u_delay (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (s1_valid),
        .in_data   (s1_data),
        .out_valid (mem_data_oe),
        .out_data  (mem_data)
    );

    assign index = count;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_zbt_write_sequencer.sv
// tb_zbt_write_sequencer
// Directed bench for zbt_write_sequencer. Three instances cover the default
// configuration, a wrapping base address and a single-entry table. Cycle c
// is the clock period following rising edge c; outputs are sampled 1 ns
// after each rising edge and inputs are changed at the same point.
module tb_zbt_write_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start_v [3];
    logic        grant_v [3];
    logic [1:0]  idx_w   [3];
    logic [35:0] val_w   [3];
    logic [18:0] addr_w  [3];
    logic        we_w    [3];
    logic [35:0] data_w  [3];
    logic        oe_w    [3];
    logic        busy_w  [3];
    logic        done_w  [3];

    // Lookup tables seen by each instance.
    assign val_w[0] = (idx_w[0] == 2'd0) ? 36'h00001F47D : 36'h0;
    assign val_w[1] = 36'h00000A000 + {34'h0, idx_w[1]};
    assign val_w[2] = (idx_w[2] == 2'd0) ? 36'h555555555 : 36'hFFFFFFFFF;

    zbt_write_sequencer #(
        .NUM_ENTRIES(4), .INDEX_WIDTH(2), .ADDR_WIDTH(19), .DATA_WIDTH(36), .BASE_ADDR(19'h00000)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .mem_grant(grant_v[0]),
        .index(idx_w[0]), .value(val_w[0]), .mem_addr(addr_w[0]), .mem_we(we_w[0]),
        .mem_data(data_w[0]), .mem_data_oe(oe_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    zbt_write_sequencer #(
        .NUM_ENTRIES(4), .INDEX_WIDTH(2), .ADDR_WIDTH(19), .DATA_WIDTH(36), .BASE_ADDR(19'h7FFFE)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .mem_grant(grant_v[1]),
        .index(idx_w[1]), .value(val_w[1]), .mem_addr(addr_w[1]), .mem_we(we_w[1]),
        .mem_data(data_w[1]), .mem_data_oe(oe_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    zbt_write_sequencer #(
        .NUM_ENTRIES(1), .INDEX_WIDTH(2), .ADDR_WIDTH(19), .DATA_WIDTH(36), .BASE_ADDR(19'h00000)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .mem_grant(grant_v[2]),
        .index(idx_w[2]), .value(val_w[2]), .mem_addr(addr_w[2]), .mem_we(we_w[2]),
        .mem_data(data_w[2]), .mem_data_oe(oe_w[2]), .busy(busy_w[2]), .done(done_w[2])
    );

    // Scoreboard state.
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [18:0] exp_addr_q [$];
    logic [35:0] exp_data_q [$];
    logic [35:0] last_data  [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs ncyc cycles on instance s. Bit c of each mask gives the input
    // driven during cycle c, or the expected output level in cycle c. Addresses
    // and data for each expected beat come from the expected queues.
    task automatic run_check(input int s, input int ncyc,
                             input logic [31:0] start_m, input logic [31:0] grant_m,
                             input logic [31:0] we_m, input logic [31:0] oe_m,
                             input logic [31:0] done_m, input logic [31:0] busy_m,
                             input logic [31:0] busy_care);
        logic [18:0] ea;
        logic [35:0] ed;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start_v[s] = start_m[c];
            grant_v[s] = grant_m[c];
            chk($sformatf("dut%0d we@%0d", s, c), {63'h0, we_w[s]}, {63'h0, we_m[c]});
            chk($sformatf("dut%0d oe@%0d", s, c), {63'h0, oe_w[s]}, {63'h0, oe_m[c]});
            chk($sformatf("dut%0d done@%0d", s, c), {63'h0, done_w[s]}, {63'h0, done_m[c]});
            if (busy_care[c]) begin
                chk($sformatf("dut%0d busy@%0d", s, c), {63'h0, busy_w[s]}, {63'h0, busy_m[c]});
            end
            if (we_m[c] && we_w[s] === 1'b1) begin
                ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 19'h0;
                chk($sformatf("dut%0d addr@%0d", s, c), {45'h0, addr_w[s]}, {45'h0, ea});
            end
            if (oe_m[c] && oe_w[s] === 1'b1) begin
                ed = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 36'h0;
                chk($sformatf("dut%0d data@%0d", s, c), {28'h0, data_w[s]}, {28'h0, ed});
                last_data[s] = ed;
            end else if (!oe_m[c]) begin
                chk($sformatf("dut%0d hold@%0d", s, c), {28'h0, data_w[s]}, {28'h0, last_data[s]});
            end
        end
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    initial begin
        // Clock/reset.
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i]   = 1'b0;
            grant_v[i]   = 1'b0;
            last_data[i] = 36'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst we", {63'h0, we_w[0]}, 64'h0);
        chk("rst oe", {63'h0, oe_w[0]}, 64'h0);
        chk("rst busy", {63'h0, busy_w[0]}, 64'h0);
        chk("rst done", {63'h0, done_w[0]}, 64'h0);
        chk("rst addr", {45'h0, addr_w[0]}, 64'h0);
        chk("rst data", {28'h0, data_w[0]}, 64'h0);
        chk("rst index", {62'h0, idx_w[0]}, 64'h0);
        reset_n = 1'b1;

        // Basic run, grant held high, start sampled at edge 0.
        start_v[0] = 1'b1;
        grant_v[0] = 1'b1;
        exp_addr_q = '{19'h0, 19'h1, 19'h2, 19'h3};
        exp_data_q = '{36'h00001F47D, 36'h0, 36'h0, 36'h0};
        run_check(0, 9, 32'h0, 32'hFFFFFFFF, 32'h1E, 32'h78, 32'h40, 32'h7E, 32'h1FE);

        // Grant low in cycles 2-3: no skipped or repeated addresses.
        start_v[0] = 1'b1;
        grant_v[0] = 1'b1;
        exp_addr_q = '{19'h0, 19'h1, 19'h2, 19'h3};
        exp_data_q = '{36'h00001F47D, 36'h0, 36'h0, 36'h0};
        run_check(0, 10, 32'h0, 32'hFFFFFFF3, 32'h66, 32'h198, 32'h100, 32'h1FE, 32'h3FE);

        // start during busy ignored; start in cycle 7 launches a second run.
        start_v[0] = 1'b1;
        grant_v[0] = 1'b1;
        exp_addr_q = '{19'h0, 19'h1, 19'h2, 19'h3, 19'h0, 19'h1, 19'h2, 19'h3};
        exp_data_q = '{36'h00001F47D, 36'h0, 36'h0, 36'h0, 36'h00001F47D, 36'h0, 36'h0, 36'h0};
        run_check(0, 16, 32'h88, 32'hFFFFFFFF, 32'h1E1E, 32'h7878, 32'h4040, 32'h7E7E, 32'hFEFE);

        // Asynchronous reset in the middle of cycle 4.
        start_v[0] = 1'b1;
        grant_v[0] = 1'b1;
        exp_addr_q = '{19'h0, 19'h1, 19'h2, 19'h3};
        exp_data_q = '{36'h00001F47D, 36'h0};
        run_check(0, 5, 32'h0, 32'hFFFFFFFF, 32'h1E, 32'h18, 32'h0, 32'h1E, 32'h1E);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async we", {63'h0, we_w[0]}, 64'h0);
        chk("async oe", {63'h0, oe_w[0]}, 64'h0);
        chk("async busy", {63'h0, busy_w[0]}, 64'h0);
        chk("async done", {63'h0, done_w[0]}, 64'h0);
        chk("async data", {28'h0, data_w[0]}, 64'h0);
        for (int i = 0; i < 3; i++) last_data[i] = 36'h0;
        @(negedge clk);
        reset_n = 1'b1;
        run_check(0, 4, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'hF);
        grant_v[0] = 1'b0;

        // Base address wraps modulo 2^19.
        start_v[1] = 1'b1;
        grant_v[1] = 1'b1;
        exp_addr_q = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
        exp_data_q = '{36'h00000A000, 36'h00000A001, 36'h00000A002, 36'h00000A003};
        run_check(1, 9, 32'h0, 32'hFFFFFFFF, 32'h1E, 32'h78, 32'h40, 32'h7E, 32'h1FE);

        // Single entry, grant withheld until cycle 5.
        start_v[2] = 1'b1;
        grant_v[2] = 1'b0;
        exp_addr_q = '{19'h0};
        exp_data_q = '{36'h555555555};
        run_check(2, 10, 32'h0, 32'hFFFFFFE0, 32'h40, 32'h100, 32'h100, 32'h1FE, 32'h3FE);

        // Final report.
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
